bullet_pool: RTL and testbench

Consumer end of the tank's firing interface. Latches the tank's one-cycle is_shooting strobe and spawns a projectile in front of the tank, facing the tank's direction. Holds up to NUM_BULLETS live projectiles, advances each one once per frame, and retires any that would leave the screen. Provides a per-pixel is_bullet flag to the colour mapper, alongside is_tank.

---
 rtl/bullet_pkg.sv | 30 +++
 rtl/bullet_slot.sv | 81 ++++++++
 rtl/bullet_pool.sv | 183 ++++++++++++++++++
 tb/tb_bullet_pool.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types and screen bounds for the projectile pool.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package bullet_pkg;

   localparam int COORD_W      = 10;
   localparam int SCREEN_X_MAX = 639;
   localparam int SCREEN_Y_MAX = 479;

   // Encoding matches the tank's tank_dir output bit-for-bit.
   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   typedef struct packed {
      logic               active;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      dir_t               dir;
   } bullet_t;

   // One extra bit so that far-edge sums never wrap before being compared.
   function automatic logic [COORD_W:0] widen(input logic [COORD_W-1:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: moves or retires on tick, loads on spawn, flags pixel hits.
// Latency: state updates one Clk after tick/load; hit is combinational from state.
// Backpressure: none; load is only asserted by the pool for a slot that is inactive.
module bullet_slot
   import bullet_pkg::*;
#(
   parameter int BULLET_SIZE = 4,
   parameter int BULLET_STEP = 4,
   parameter int X_MAX       = SCREEN_X_MAX,
   parameter int Y_MAX       = SCREEN_Y_MAX
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               tick,
   input  logic               load,
   input  logic [COORD_W-1:0] load_x,
   input  logic [COORD_W-1:0] load_y,
   input  dir_t               load_dir,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   output logic               active,
   output logic               active_nxt,
   output logic               hit
);

   localparam logic [COORD_W-1:0] STEP_N = COORD_W'(BULLET_STEP);
   localparam logic [COORD_W:0]   REACH  = (COORD_W+1)'(BULLET_STEP + BULLET_SIZE - 1);
   localparam logic [COORD_W:0]   SPAN   = (COORD_W+1)'(BULLET_SIZE - 1);
   localparam logic [COORD_W:0]   X_LIM  = (COORD_W+1)'(X_MAX);
   localparam logic [COORD_W:0]   Y_LIM  = (COORD_W+1)'(Y_MAX);

   bullet_t cur;
   bullet_t nxt;

   // Next state: spawn load, else one step in the stored direction or retire at the edge.
   always_comb begin
      nxt = cur;
      if (load) begin
         nxt.active = 1'b1;
         nxt.x      = load_x;
         nxt.y      = load_y;
         nxt.dir    = load_dir;
      end else if (tick && cur.active) begin
         case (cur.dir)
            DIR_UP: begin
               if (cur.y < STEP_N) nxt.active = 1'b0;
               else                nxt.y      = cur.y - STEP_N;
            end
            DIR_DOWN: begin
               if (widen(cur.y) + REACH > Y_LIM) nxt.active = 1'b0;
               else                              nxt.y      = cur.y + STEP_N;
            end
            DIR_LEFT: begin
               if (cur.x < STEP_N) nxt.active = 1'b0;
               else                nxt.x      = cur.x - STEP_N;
            end
            DIR_RIGHT: begin
               if (widen(cur.x) + REACH > X_LIM) nxt.active = 1'b0;
               else                              nxt.x      = cur.x + STEP_N;
            end
         endcase
      end
   end

   // Slot state register; reset kills the bullet immediately.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) cur <= '0;
      else          cur <= nxt;
   end

   // Square hit test against the current pixel.
   always_comb begin
      hit = cur.active
         && (DrawX >= cur.x) && (widen(DrawX) <= widen(cur.x) + SPAN)
         && (DrawY >= cur.y) && (widen(DrawY) <= widen(cur.y) + SPAN);
   end

   assign active     = cur.active;
   assign active_nxt = nxt.active;

endmodule

// File: rtl/bullet_pool.sv
// Projectile pool: latches fire strobes, spawns/advances/retires bullets per frame tick, drives is_bullet.
// Latency: tick 1 Clk after frame_clk rise; fire_ack/fire_drop/active_count 1 Clk after tick; is_bullet combinational.
// Backpressure: refusals (cooldown, full pool, off-screen) pulse fire_drop; FIRE_REQ_HOLD_EN retries cooldown/full refusals instead.
module bullet_pool
   import bullet_pkg::*;
#(
   parameter int NUM_BULLETS     = 4,
   parameter int BULLET_SIZE     = 4,
   parameter int BULLET_STEP     = 4,
   parameter int COOLDOWN_FRAMES = 15,
   parameter int TANK_W          = 32,
   parameter int TANK_H          = 32,
   parameter int X_MAX           = SCREEN_X_MAX,
   parameter int Y_MAX           = SCREEN_Y_MAX
) (
   input  logic                             Clk,
   input  logic                             Reset_n,
   input  logic                             frame_clk,
   input  logic                             is_shooting,
   input  logic [9:0]                       tank_X,
   input  logic [9:0]                       tank_Y,
   input  logic [1:0]                       tank_dir,
   input  logic [9:0]                       DrawX,
   input  logic [9:0]                       DrawY,
   output logic                             is_bullet,
   output logic                             fire_ack,
   output logic                             fire_drop,
   output logic [$clog2(NUM_BULLETS+1)-1:0] active_count
);

   localparam int CNT_W = $clog2(NUM_BULLETS + 1);
   localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

   localparam logic [COORD_W:0] SIZE_W = (COORD_W+1)'(BULLET_SIZE);
   localparam logic [COORD_W:0] SPAN   = (COORD_W+1)'(BULLET_SIZE - 1);
   localparam logic [COORD_W:0] X_LIM  = (COORD_W+1)'(X_MAX);
   localparam logic [COORD_W:0] Y_LIM  = (COORD_W+1)'(Y_MAX);
   localparam logic [COORD_W:0] TW     = (COORD_W+1)'(TANK_W);
   localparam logic [COORD_W:0] TH     = (COORD_W+1)'(TANK_H);
   localparam logic [COORD_W:0] CX_OFF = (COORD_W+1)'(TANK_W/2 - BULLET_SIZE/2);
   localparam logic [COORD_W:0] CY_OFF = (COORD_W+1)'(TANK_H/2 - BULLET_SIZE/2);

   logic                   frame_d;
   logic                   tick;
   logic                   fire_req;
   logic [CD_W-1:0]        cooldown;

   logic [NUM_BULLETS-1:0] slot_act;
   logic [NUM_BULLETS-1:0] slot_act_nxt;
   logic [NUM_BULLETS-1:0] slot_hit;
   logic [NUM_BULLETS-1:0] free_vec;
   logic [NUM_BULLETS-1:0] sel_vec;
   logic [NUM_BULLETS-1:0] load_vec;

   logic [COORD_W:0]       tx, ty, cx, cy;
   logic [COORD_W:0]       sx, sy;
   logic                   spawn_ok;
   logic                   req_eff, room, cd_zero;
   logic                   spawn, refuse, hold;
   logic [CNT_W-1:0]       pop;

   // Spawn point just outside the tank's facing edge; reject it if any part would be off-screen.
   always_comb begin
      tx       = widen(tank_X);
      ty       = widen(tank_Y);
      cx       = tx + CX_OFF;
      cy       = ty + CY_OFF;
      sx       = '0;
      sy       = '0;
      spawn_ok = 1'b0;
      case (dir_t'(tank_dir))
         DIR_UP: begin
            sx       = cx;
            sy       = (ty >= SIZE_W) ? ty - SIZE_W : '0;
            spawn_ok = (ty >= SIZE_W) && (cx + SPAN <= X_LIM);
         end
         DIR_DOWN: begin
            sx       = cx;
            sy       = ty + TH;
            spawn_ok = (sy + SPAN <= Y_LIM) && (cx + SPAN <= X_LIM);
         end
         DIR_LEFT: begin
            sx       = (tx >= SIZE_W) ? tx - SIZE_W : '0;
            sy       = cy;
            spawn_ok = (tx >= SIZE_W) && (cy + SPAN <= Y_LIM);
         end
         DIR_RIGHT: begin
            sx       = tx + TW;
            sy       = cy;
            spawn_ok = (sx + SPAN <= X_LIM) && (cy + SPAN <= Y_LIM);
         end
      endcase
   end

   // Fire decision on a tick; free slots are those inactive before the tick, lowest index wins.
   always_comb begin
      free_vec = ~slot_act;
      sel_vec  = free_vec & (~free_vec + NUM_BULLETS'(1));
      req_eff  = fire_req | is_shooting;
      room     = |free_vec;
      cd_zero  = (cooldown == '0);
      spawn    = tick && req_eff && cd_zero && room && spawn_ok;
`ifdef FIRE_REQ_HOLD_EN
      hold     = tick && req_eff && !(cd_zero && room);
`else
      hold     = 1'b0;
`endif
      refuse   = tick && req_eff && !spawn && !hold;
      load_vec = spawn ? sel_vec : '0;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_BULLETS; g++) begin : g_slot
         bullet_slot #(
            .BULLET_SIZE (BULLET_SIZE),
            .BULLET_STEP (BULLET_STEP),
            .X_MAX       (X_MAX),
            .Y_MAX       (Y_MAX)
         ) u_slot (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .tick       (tick),
            .load       (load_vec[g]),
            .load_x     (sx[COORD_W-1:0]),
            .load_y     (sy[COORD_W-1:0]),
            .load_dir   (dir_t'(tank_dir)),
            .DrawX      (DrawX),
            .DrawY      (DrawY),
            .active     (slot_act[g]),
            .active_nxt (slot_act_nxt[g]),
            .hit        (slot_hit[g])
         );
      end
   endgenerate

   // Population of the slot state that will be loaded on this edge.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_BULLETS; i++) pop = pop + CNT_W'(slot_act_nxt[i]);
   end

   assign is_bullet = |slot_hit;

   // Frame tick: one-Clk pulse on the registered rising edge of frame_clk.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_d <= 1'b0;
         tick    <= 1'b0;
      end else begin
         frame_d <= frame_clk;
         tick    <= frame_clk & ~frame_d;
      end
   end

   // Request latch: catches short strobes between ticks, consumed (or held) at each tick.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)         fire_req <= 1'b0;
      else if (tick)        fire_req <= hold;
      else if (is_shooting) fire_req <= 1'b1;
   end

   // Cooldown counts frame ticks after each spawn.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)             cooldown <= '0;
      else if (spawn)           cooldown <= CD_W'(COOLDOWN_FRAMES);
      else if (tick && !cd_zero) cooldown <= cooldown - CD_W'(1);
   end

   // Outcome pulses and live-slot count, aligned with the slot state update.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fire_ack     <= 1'b0;
         fire_drop    <= 1'b0;
         active_count <= '0;
      end else begin
         fire_ack     <= spawn;
         fire_drop    <= refuse;
         active_count <= pop;
      end
   end

endmodule

// File: tb/tb_bullet_pool.sv
module tb_bullet_pool;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       frame_clk;
   logic       is_shooting;
   logic [9:0] tank_X, tank_Y, DrawX, DrawY;
   logic [1:0] tank_dir;
   logic       is_bullet, fire_ack, fire_drop;
   logic [2:0] active_count;

   int checks = 0;
   int errors = 0;
   logic [1:0] sb[$];

   localparam logic [1:0] EV_NONE = 2'b00;
   localparam logic [1:0] EV_ACK  = 2'b10;
   localparam logic [1:0] EV_DROP = 2'b01;

   bullet_pool dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .frame_clk    (frame_clk),
      .is_shooting  (is_shooting),
      .tank_X       (tank_X),
      .tank_Y       (tank_Y),
      .tank_dir     (tank_dir),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .is_bullet    (is_bullet),
      .fire_ack     (fire_ack),
      .fire_drop    (fire_drop),
      .active_count (active_count)
   );

   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Every ack/drop pulse must match the next queued expectation.
   always @(negedge Clk) begin
      if (Reset_n === 1'b1 && (fire_ack !== 1'b0 || fire_drop !== 1'b0)) begin
         if (sb.size() == 0) chk("unexpected_pulse", {30'd0, fire_ack, fire_drop}, 32'd0);
         else                chk("fire_event", {30'd0, fire_ack, fire_drop}, {30'd0, sb.pop_front()});
      end
   end

   task automatic set_tank(input int x, input int y, input logic [1:0] d);
      tank_X   = 10'(x);
      tank_Y   = 10'(y);
      tank_dir = d;
   endtask

   task automatic shoot();
      @(negedge Clk) is_shooting = 1'b1;
      @(negedge Clk) is_shooting = 1'b0;
   endtask

   task automatic tick(input logic [1:0] exp);
      if (exp != EV_NONE) sb.push_back(exp);
      @(negedge Clk) frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      chk("event_drained", sb.size(), 32'd0);
   endtask

   task automatic probe(input string tag, input int x, input int y, input logic exp);
      DrawX = 10'(x);
      DrawY = 10'(y);
      #1;
      chk(tag, {31'd0, is_bullet}, {31'd0, exp});
   endtask

   task automatic do_reset();
      @(negedge Clk) Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   initial begin
      Reset_n = 1'b0; frame_clk = 1'b0; is_shooting = 1'b0;
      DrawX = '0; DrawY = '0;
      set_tank(500, 240, 2'b00);
      repeat (3) @(negedge Clk);
      chk("rst_count", active_count, 0);
      chk("rst_ack", fire_ack, 0);
      chk("rst_drop", fire_drop, 0);
      probe("rst_pix", 0, 0, 1'b0);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Spawn up in front of the tank, then one step up.
      set_tank(500, 240, 2'b00);
      shoot();
      tick(EV_ACK);
      chk("up_count", active_count, 1);
      probe("up_spawn_in", 514, 236, 1'b1);
      probe("up_spawn_left", 513, 236, 1'b0);
      tick(EV_NONE);
      probe("up_mv_tl", 514, 232, 1'b1);
      probe("up_mv_br", 517, 235, 1'b1);
      probe("up_mv_right", 518, 232, 1'b0);
      probe("up_mv_below", 514, 236, 1'b0);
      probe("up_mv_above", 514, 231, 1'b0);

      // Right-edge retire: 632 -> 636 -> gone.
      do_reset();
      set_tank(600, 200, 2'b11);
      shoot();
      tick(EV_ACK);
      probe("rt_spawn", 632, 214, 1'b1);
      tick(EV_NONE);
      probe("rt_636", 636, 214, 1'b1);
      chk("rt_count1", active_count, 1);
      tick(EV_NONE);
      chk("rt_count0", active_count, 0);
      probe("rt_gone", 636, 214, 1'b0);

      // Cooldown: 15 refused ticks, then accepted.
      do_reset();
      set_tank(300, 240, 2'b00);
      shoot();
      tick(EV_ACK);
      for (int k = 1; k <= 15; k++) begin
`ifdef FIRE_REQ_HOLD_EN
         if (k == 1) shoot();
         tick(k == 15 ? EV_NONE : EV_NONE);
`else
         shoot();
         tick(EV_DROP);
`endif
         chk("cd_count", active_count, 1);
      end
`ifdef FIRE_REQ_HOLD_EN
      tick(EV_ACK);
`else
      shoot();
      tick(EV_ACK);
`endif
      chk("cd_count2", active_count, 2);

      // Off-screen left spawn refused; x=4 is the closest accepted position.
      do_reset();
      set_tank(0, 240, 2'b10);
      shoot();
      tick(EV_DROP);
      chk("off_count", active_count, 0);
      set_tank(4, 240, 2'b10);
      shoot();
      tick(EV_ACK);
      probe("left_edge", 0, 254, 1'b1);
      tick(EV_NONE);
      chk("left_retire", active_count, 0);

      // Pool full.
      do_reset();
      set_tank(300, 440, 2'b00);
      for (int i = 0; i < 4; i++) begin
         shoot();
         tick(EV_ACK);
         repeat (15) tick(EV_NONE);
      end
      chk("full_count", active_count, 4);
      shoot();
`ifdef FIRE_REQ_HOLD_EN
      tick(EV_NONE);
      chk("full_held", active_count, 4);
      repeat (46) tick(EV_NONE);
      tick(EV_ACK);
      chk("full_retry", active_count, 4);
`else
      tick(EV_DROP);
      chk("full_drop", active_count, 4);
`endif

      // Reset mid-flight with three live bullets.
      do_reset();
      set_tank(300, 240, 2'b00);
      for (int i = 0; i < 3; i++) begin
         shoot();
         tick(EV_ACK);
         if (i < 2) repeat (15) tick(EV_NONE);
      end
      chk("mid_count3", active_count, 3);
      probe("mid_pix_live", 314, 236, 1'b1);
      @(negedge Clk) Reset_n = 1'b0;
      #1;
      chk("mid_rst_count", active_count, 0);
      chk("mid_rst_pix", is_bullet, 0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      shoot();
      tick(EV_ACK);
      chk("mid_after", active_count, 1);

      repeat (3) @(negedge Clk);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
